fpu_ss_wb_arbiter: RTL and testbench
====================================

FPU_SS_WB_ARBITER -- requirements
Module: fpu_ss_wb_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_PRIO, default 1, meaning fixed-priority winner on FPR conflict (1 = memory, 0 = FPU).
REQ-002 The block SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port fpu_valid_i / fpu_ready_o  in/out  1/1  FPU result handshake.
REQ-005 The block SHALL have port fpu_result_i  input  32  FPU result data.
REQ-006 The block SHALL have port fpu_tag_i  input  10  FPU tag {addr[4:0], rd_is_fp, id[3:0]}.
REQ-007 The block SHALL have port mem_valid_i / mem_ready_o  in/out  1/1  load-response handshake (FP loads only).
REQ-008 The block SHALL have ports mem_rdata_i  input  32 (load data) and mem_tag_i  input  10 (tag, same layout).
REQ-009 The block SHALL have ports fpr_we_o  output  1, fpr_waddr_o  output  5, fpr_wdata_o  output  32: FP register-file write port, no backpressure.
REQ-010 The block SHALL have port result_valid_o / result_ready_i  out/in  1/1  integer-result handshake to core.
REQ-011 The block SHALL have ports result_data_o  output  32, result_rd_o  output  5, result_id_o  output  4.

Function
REQ-012 A transfer SHALL occur on a source when valid and ready are both high in the same cycle.
REQ-013 Targets: FPU with rd_is_fp=1 -> FPR path; FPU with rd_is_fp=0 -> integer path; memory -> FPR path regardless of its rd_is_fp bit.
REQ-014 The FPR path SHALL be a one-cycle registered stage: a transfer in cycle N drives fpr_we_o=1 with tag addr and data in cycle N+1 only.
REQ-015 The FPR path SHALL accept at most one transfer per cycle; it is never blocked by downstream.
REQ-016 The integer path SHALL be a one-entry output register: load in cycle N, result_valid_o=1 from N+1 until the cycle result_ready_i=1.
REQ-017 The integer register SHALL accept a new entry when empty or when result_ready_i=1 in the same cycle (back-to-back, no bubble).
REQ-018 Both sources targeting the FPR path simultaneously SHALL constitute a conflict; exactly one is granted, the other sees ready=0.
REQ-019 FPU to integer path and memory to FPR path in the same cycle SHALL both be granted.
REQ-020 fpu_ready_o SHALL be 0 when the FPU targets the integer path while it is full and result_ready_i=0.
REQ-021 Ready outputs SHALL be combinational from the valids, tags, and state; ready may be 1 without valid only when the target path is free.
REQ-022 result_data_o, result_rd_o, and result_id_o SHALL remain stable while result_valid_o=1 and result_ready_i=0.
REQ-023 fpr_waddr_o and fpr_wdata_o SHALL be don't-care when fpr_we_o=0.

Reset
REQ-024 While rst_i=1 at a clock edge: fpr_we_o=0, result_valid_o=0, all data/address/id registers=0, and the round-robin pointer selects memory.
REQ-025 Reset during a pending integer result SHALL drop it; no writeback for it SHALL appear after reset.
REQ-026 fpu_ready_o and mem_ready_o SHALL be 0 while rst_i=1.

Configuration
REQ-027 With macro FPU_SS_WB_RR_EN defined, FPR conflicts SHALL be resolved round-robin: the winner is the source not granted at the last conflict, and the pointer updates only on a conflict.
REQ-028 Without FPU_SS_WB_RR_EN, FPR conflicts SHALL be resolved by fixed priority per MEM_PRIO, and no pointer state SHALL exist.

Verification
REQ-029 Single FPR write: FPU valid, tag {addr=5'd3, fp=1, id=4'd2}, data 32'h3F800000 -> fpr_we_o=1, waddr=3, wdata=32'h3F800000 exactly one cycle later.
REQ-030 Integer backpressure: FPU {addr=5'd10, fp=0, id=4'd7}, data 32'h1, result_ready_i=0 for 3 cycles -> result_valid_o held 3 cycles, stable data; second FPU int result sees fpu_ready_o=0 until the release cycle, then loads with no bubble.
REQ-031 Conflict, fixed priority (MEM_PRIO=1, no macro): both sources valid to FPR for 2 cycles -> memory granted both cycles, FPU stalled.
REQ-032 Conflict, round-robin (macro defined): both sources valid to FPR for 4 cycles -> grants mem, fpu, mem, fpu.
REQ-033 Parallel: FPU int result plus memory FPR write in the same cycle -> both ready=1, result_valid_o and fpr_we_o both asserted next cycle.
REQ-034 Reset mid-operation: assert rst_i while result_valid_o=1 -> next cycle result_valid_o=0 and fpr_we_o=0; round-robin grants memory first at the next conflict.

Source files
------------

// File: rtl/fpu_ss_wb_arbiter.sv
// FPU subsystem writeback arbiter: FPU/load results to FPR write port and integer result register.
// Optional macro FPU_SS_WB_RR_EN selects round-robin FPR conflict resolution.
module fpu_ss_wb_arbiter #(
   parameter int unsigned MEM_PRIO = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fpu_valid_i,
   output logic        fpu_ready_o,
   input  logic [31:0] fpu_result_i,
   input  logic [9:0]  fpu_tag_i,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic [31:0] mem_rdata_i,
   input  logic [9:0]  mem_tag_i,
   output logic        fpr_we_o,
   output logic [4:0]  fpr_waddr_o,
   output logic [31:0] fpr_wdata_o,
   output logic        result_valid_o,
   input  logic        result_ready_i,
   output logic [31:0] result_data_o,
   output logic [4:0]  result_rd_o,
   output logic [3:0]  result_id_o
);

   logic        fpu_fp;
   logic        conflict;
   logic        mem_win;
   logic        int_free;
   logic        fpu_fire;
   logic        mem_fire;

   logic        fpr_we_q, fpr_we_d;
   logic [4:0]  fpr_waddr_q, fpr_waddr_d;
   logic [31:0] fpr_wdata_q, fpr_wdata_d;
   logic        res_valid_q, res_valid_d;
   logic [31:0] res_data_q, res_data_d;
   logic [4:0]  res_rd_q, res_rd_d;
   logic [3:0]  res_id_q, res_id_d;

   // Loads always target the FPR file, so the rest of their tag is ignored.
   logic        unused_mem_tag;
   assign unused_mem_tag = ^mem_tag_i[4:0];

   assign fpu_fp   = fpu_tag_i[4];
   assign conflict = fpu_valid_i & fpu_fp & mem_valid_i;
   assign int_free = ~res_valid_q | result_ready_i;

`ifdef FPU_SS_WB_RR_EN
   logic rr_mem_q, rr_mem_d;

   assign mem_win  = rr_mem_q;
   assign rr_mem_d = conflict ? ~rr_mem_q : rr_mem_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_mem_q <= 1'b1;
      end else begin
         rr_mem_q <= rr_mem_d;
      end
   end
`else
   assign mem_win = (MEM_PRIO != 0);
`endif

   assign mem_ready_o = ~rst_i & (~conflict | mem_win);
   assign fpu_ready_o = ~rst_i & (fpu_fp ? (~conflict | ~mem_win) : int_free);

   assign mem_fire = mem_valid_i & mem_ready_o;
   assign fpu_fire = fpu_valid_i & fpu_ready_o;

   always_comb begin
      fpr_we_d    = mem_fire | (fpu_fire & fpu_fp);
      fpr_waddr_d = fpr_waddr_q;
      fpr_wdata_d = fpr_wdata_q;
      if (mem_fire) begin
         fpr_waddr_d = mem_tag_i[9:5];
         fpr_wdata_d = mem_rdata_i;
      end else if (fpu_fire & fpu_fp) begin
         fpr_waddr_d = fpu_tag_i[9:5];
         fpr_wdata_d = fpu_result_i;
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_id_d    = res_id_q;
      if (fpu_fire & ~fpu_fp) begin
         res_valid_d = 1'b1;
         res_data_d  = fpu_result_i;
         res_rd_d    = fpu_tag_i[9:5];
         res_id_d    = fpu_tag_i[3:0];
      end else if (result_ready_i) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fpr_we_q    <= 1'b0;
         fpr_waddr_q <= '0;
         fpr_wdata_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         res_id_q    <= '0;
      end else begin
         fpr_we_q    <= fpr_we_d;
         fpr_waddr_q <= fpr_waddr_d;
         fpr_wdata_q <= fpr_wdata_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_id_q    <= res_id_d;
      end
   end

   assign fpr_we_o       = fpr_we_q;
   assign fpr_waddr_o    = fpr_waddr_q;
   assign fpr_wdata_o    = fpr_wdata_q;
   assign result_valid_o = res_valid_q;
   assign result_data_o  = res_data_q;
   assign result_rd_o    = res_rd_q;
   assign result_id_o    = res_id_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed and randomized bench for fpu_ss_wb_arbiter against a cycle-level reference model.
// Honours FPU_SS_WB_RR_EN for the conflict-resolution expectations.
module tb_fpu_ss_wb_arbiter;

   localparam int unsigned MP = 1;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        fpu_valid_i = 1'b0;
   logic        fpu_ready_o;
   logic [31:0] fpu_result_i = '0;
   logic [9:0]  fpu_tag_i = '0;
   logic        mem_valid_i = 1'b0;
   logic        mem_ready_o;
   logic [31:0] mem_rdata_i = '0;
   logic [9:0]  mem_tag_i = '0;
   logic        fpr_we_o;
   logic [4:0]  fpr_waddr_o;
   logic [31:0] fpr_wdata_o;
   logic        result_valid_o;
   logic        result_ready_i = 1'b0;
   logic [31:0] result_data_o;
   logic [4:0]  result_rd_o;
   logic [3:0]  result_id_o;

   always #5 clk = ~clk;

   fpu_ss_wb_arbiter #(.MEM_PRIO(MP)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_tag_i(fpu_tag_i),
      .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
      .mem_rdata_i(mem_rdata_i), .mem_tag_i(mem_tag_i),
      .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_data_o(result_data_o), .result_rd_o(result_rd_o),
      .result_id_o(result_id_o)
   );

   int total = 0;
   int passed = 0;
   int fails = 0;

   // Reference model state
   logic        exp_we = 1'b0;
   logic [4:0]  exp_wa = '0;
   logic [31:0] exp_wd = '0;
   logic        exp_rv = 1'b0;
   logic [31:0] exp_data = '0;
   logic [4:0]  exp_rd = '0;
   logic [3:0]  exp_id = '0;
   logic        mem_next = 1'b1;
   logic        fr_s, mr_s;

   function automatic logic [9:0] mk(input logic [4:0] a, input logic fp, input logic [3:0] id);
      return {a, fp, id};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [9:0] ft, input logic [31:0] fd,
                        input logic mv, input logic [9:0] mt, input logic [31:0] md,
                        input logic rr);
      fpu_valid_i = fv; fpu_tag_i = ft; fpu_result_i = fd;
      mem_valid_i = mv; mem_tag_i = mt; mem_rdata_i = md;
      result_ready_i = rr;
   endtask

   // One clock: check readies mid-cycle, advance the model at the edge, check outputs after.
   task automatic cycle();
      logic ffp, conf, mwin, ifree, exp_fr, exp_mr, ffire, mfire;
      #4;
      ffp  = fpu_tag_i[4];
      conf = fpu_valid_i && ffp && mem_valid_i;
`ifdef FPU_SS_WB_RR_EN
      mwin = mem_next;
`else
      mwin = (MP != 0);
`endif
      ifree  = !exp_rv || result_ready_i;
      exp_mr = !rst_i && !(conf && !mwin);
      exp_fr = !rst_i && (ffp ? !(conf && mwin) : ifree);
      fr_s = fpu_ready_o;
      mr_s = mem_ready_o;
      chk("fpu_ready", {31'd0, fr_s}, {31'd0, exp_fr});
      chk("mem_ready", {31'd0, mr_s}, {31'd0, exp_mr});
      @(posedge clk);
      mfire = mem_valid_i && exp_mr;
      ffire = fpu_valid_i && exp_fr;
      if (rst_i) begin
         exp_we = 0; exp_wa = '0; exp_wd = '0;
         exp_rv = 0; exp_data = '0; exp_rd = '0; exp_id = '0;
         mem_next = 1'b1;
      end else begin
         exp_we = mfire || (ffire && ffp);
         if (mfire) begin
            exp_wa = mem_tag_i[9:5]; exp_wd = mem_rdata_i;
         end else if (ffire && ffp) begin
            exp_wa = fpu_tag_i[9:5]; exp_wd = fpu_result_i;
         end
         if (ffire && !ffp) begin
            exp_rv = 1; exp_data = fpu_result_i;
            exp_rd = fpu_tag_i[9:5]; exp_id = fpu_tag_i[3:0];
         end else if (result_ready_i) begin
            exp_rv = 0;
         end
         if (conf) mem_next = !mwin;
      end
      #1;
      chk("fpr_we", {31'd0, fpr_we_o}, {31'd0, exp_we});
      if (exp_we) begin
         chk("fpr_waddr", {27'd0, fpr_waddr_o}, {27'd0, exp_wa});
         chk("fpr_wdata", fpr_wdata_o, exp_wd);
      end
      chk("result_valid", {31'd0, result_valid_o}, {31'd0, exp_rv});
      if (exp_rv) begin
         chk("result_data", result_data_o, exp_data);
         chk("result_rd", {27'd0, result_rd_o}, {27'd0, exp_rd});
         chk("result_id", {28'd0, result_id_o}, {28'd0, exp_id});
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset, with valids asserted in the second reset cycle
      rst_i = 1;
      drive(0, '0, '0, 0, '0, '0, 0);
      cycle();
      drive(1, mk(5'd4, 1'b1, 4'd1), 32'h55, 1, mk(5'd6, 1'b1, 4'd0), 32'h66, 0);
      cycle();
      chk("rst_fpu_ready", {31'd0, fr_s}, 32'd0);
      chk("rst_mem_ready", {31'd0, mr_s}, 32'd0);
      chk("rst_wdata", fpr_wdata_o, 32'd0);
      chk("rst_waddr", {27'd0, fpr_waddr_o}, 32'd0);
      chk("rst_rdata", result_data_o, 32'd0);
      chk("rst_rd", {27'd0, result_rd_o}, 32'd0);
      chk("rst_id", {28'd0, result_id_o}, 32'd0);
      rst_i = 0;
      drive(0, '0, '0, 0, '0, '0, 1);
      cycle();

      // Single FPR write
      drive(1, mk(5'd3, 1'b1, 4'd2), 32'h3F800000, 0, '0, '0, 1);
      cycle();
      chk("w1_ready", {31'd0, fr_s}, 32'd1);
      chk("w1_we", {31'd0, fpr_we_o}, 32'd1);
      chk("w1_waddr", {27'd0, fpr_waddr_o}, 32'd3);
      chk("w1_wdata", fpr_wdata_o, 32'h3F800000);
      drive(0, '0, '0, 0, '0, '0, 1);
      cycle();
      chk("w1_we_once", {31'd0, fpr_we_o}, 32'd0);

      // Integer backpressure
      drive(1, mk(5'd10, 1'b0, 4'd7), 32'h1, 0, '0, '0, 0);
      cycle();
      chk("bp_load_ready", {31'd0, fr_s}, 32'd1);
      drive(1, mk(5'd11, 1'b0, 4'd8), 32'h2, 0, '0, '0, 0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("bp_stall_ready", {31'd0, fr_s}, 32'd0);
         chk("bp_hold_valid", {31'd0, result_valid_o}, 32'd1);
         chk("bp_hold_data", result_data_o, 32'h1);
         chk("bp_hold_id", {28'd0, result_id_o}, 32'd7);
      end
      result_ready_i = 1;
      cycle();
      chk("bp_release_ready", {31'd0, fr_s}, 32'd1);
      chk("bp_next_valid", {31'd0, result_valid_o}, 32'd1);
      chk("bp_next_data", result_data_o, 32'h2);
      chk("bp_next_id", {28'd0, result_id_o}, 32'd8);
      drive(0, '0, '0, 0, '0, '0, 1);
      cycle();
      chk("bp_drain", {31'd0, result_valid_o}, 32'd0);

      // FPR conflict
      drive(1, mk(5'd20, 1'b1, 4'd3), 32'hF0F0, 1, mk(5'd21, 1'b0, 4'd0), 32'hAB, 1);
`ifdef FPU_SS_WB_RR_EN
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_mem_grant", {31'd0, mr_s}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_fpu_grant", {31'd0, fr_s}, (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("rr_waddr", {27'd0, fpr_waddr_o}, (i % 2 == 0) ? 32'd21 : 32'd20);
      end
`else
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("fp_mem_grant", {31'd0, mr_s}, 32'd1);
         chk("fp_fpu_stall", {31'd0, fr_s}, 32'd0);
         chk("fp_waddr", {27'd0, fpr_waddr_o}, 32'd21);
         chk("fp_wdata", fpr_wdata_o, 32'hAB);
      end
`endif

      // Parallel integer result and memory FPR write
      drive(1, mk(5'd12, 1'b0, 4'd3), 32'hAA, 1, mk(5'd7, 1'b1, 4'd0), 32'hBB, 1);
      cycle();
      chk("par_fpu_ready", {31'd0, fr_s}, 32'd1);
      chk("par_mem_ready", {31'd0, mr_s}, 32'd1);
      chk("par_rvalid", {31'd0, result_valid_o}, 32'd1);
      chk("par_rdata", result_data_o, 32'hAA);
      chk("par_we", {31'd0, fpr_we_o}, 32'd1);
      chk("par_waddr", {27'd0, fpr_waddr_o}, 32'd7);
      chk("par_wdata", fpr_wdata_o, 32'hBB);

      // Reset while an integer result is pending
      drive(1, mk(5'd9, 1'b0, 4'd5), 32'h77, 0, '0, '0, 0);
      cycle();
      chk("mr_pending", {31'd0, result_valid_o}, 32'd1);
      rst_i = 1;
      drive(0, '0, '0, 1, mk(5'd2, 1'b1, 4'd0), 32'h9, 0);
      cycle();
      chk("mr_rvalid", {31'd0, result_valid_o}, 32'd0);
      chk("mr_we", {31'd0, fpr_we_o}, 32'd0);
      rst_i = 0;
      drive(1, mk(5'd1, 1'b1, 4'd0), 32'h11, 1, mk(5'd2, 1'b1, 4'd0), 32'h22, 1);
      cycle();
      chk("mr_first_mem", {31'd0, mr_s}, 32'd1);
      chk("mr_first_fpu", {31'd0, fr_s}, 32'd0);
      chk("mr_no_stale", {31'd0, result_valid_o}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         rst_i = ($urandom_range(0, 59) == 0);
         fpu_valid_i = ($urandom_range(0, 3) != 0);
         fpu_tag_i = 10'($urandom);
         fpu_result_i = $urandom;
         mem_valid_i = ($urandom_range(0, 2) != 0);
         mem_tag_i = 10'($urandom);
         mem_rdata_i = $urandom;
         result_ready_i = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
